// File: rtl/ddr3_frame_pkg.sv
// Shared constants and address helper for the DDR3 frame-buffer manager.
package ddr3_frame_pkg;
  localparam int BUF_IDX_W   = 2;
  localparam int BUF_NUM_MIN = 2;
  localparam int BUF_NUM_MAX = 4;
  // Wide enough that the elaboration-time range check cannot itself overflow.
  localparam int CALC_W      = 64;

  function automatic logic [CALC_W-1:0] buf_base(
    input logic [CALC_W-1:0]    base,
    input logic [CALC_W-1:0]    span,
    input logic [BUF_IDX_W-1:0] idx
  );
    return base + span * CALC_W'(idx);
  endfunction
endpackage

// File: rtl/ddr3_buf_sel.sv
// Combinational next-write-buffer selector: first buffer after cur_idx that is
// neither being read nor holding the ready frame, else sacrifice the ready one.
module ddr3_buf_sel
  import ddr3_frame_pkg::*;
#(
  parameter int BUF_NUM = 3
) (
  input  logic [BUF_IDX_W-1:0] cur_idx,
  input  logic [BUF_IDX_W-1:0] rd_idx,
  input  logic                 rd_active,
  input  logic [BUF_IDX_W-1:0] ready_idx,
  input  logic                 ready_vld,
  output logic [BUF_IDX_W-1:0] sel_idx,
  output logic                 overwrite
);
  logic [BUF_IDX_W-1:0] cand [BUF_NUM];
  logic                 found_free;
  logic                 found_fb;
  logic [BUF_IDX_W-1:0] free_idx;
  logic [BUF_IDX_W-1:0] fb_idx;

  for (genvar gi = 0; gi < BUF_NUM; gi++) begin : g_cand
    assign cand[gi] = BUF_IDX_W'((int'(cur_idx) + gi + 1) % BUF_NUM);
  end

  always_comb begin
    found_free = 1'b0;
    found_fb   = 1'b0;
    free_idx   = '0;
    fb_idx     = '0;
    for (int k = 0; k < BUF_NUM; k++) begin
      if (!found_free && !(rd_active && cand[k] == rd_idx)
          && !(ready_vld && cand[k] == ready_idx)) begin
        found_free = 1'b1;
        free_idx   = cand[k];
      end
      // Fallback ignores the ready frame; only the reader's buffer is sacred.
      if (!found_fb && !(rd_active && cand[k] == rd_idx)) begin
        found_fb = 1'b1;
        fb_idx   = cand[k];
      end
    end
    sel_idx   = found_free ? free_idx : fb_idx;
    overwrite = !found_free;
  end
endmodule

// File: rtl/ddr3_frame_buf_ctrl.sv
// N-buffer frame manager: hands DDR3 address windows to writer and reader so
// they never share a buffer; the reader always gets the newest complete frame.
module ddr3_frame_buf_ctrl
  import ddr3_frame_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 28,
  parameter int                    BUF_NUM    = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 28'h000_0000,
  parameter logic [ADDR_WIDTH-1:0] FRAME_SPAN = 28'h020_0000,
  parameter int                    CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_frame_start,
  input  logic                  wr_frame_done,
  input  logic                  rd_frame_start,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_address_beign,
  output logic [ADDR_WIDTH-1:0] wr_address_end,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_address_beign,
  output logic [ADDR_WIDTH-1:0] rd_address_end,
  output logic [BUF_IDX_W-1:0]  wr_buf_idx,
  output logic [BUF_IDX_W-1:0]  rd_buf_idx,
  output logic                  frame_valid,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);
  localparam logic [CALC_W-1:0] TOP_ADDR =
    CALC_W'(BASE_ADDR) + CALC_W'(BUF_NUM) * CALC_W'(FRAME_SPAN);
  localparam logic [CALC_W-1:0] ADDR_LIMIT = CALC_W'(1) << ADDR_WIDTH;

  if (BUF_NUM < BUF_NUM_MIN || BUF_NUM > BUF_NUM_MAX) begin : g_bad_buf_num
    $error("ddr3_frame_buf_ctrl: BUF_NUM must be 2..4");
  end
  if (TOP_ADDR > ADDR_LIMIT) begin : g_bad_span
    $error("ddr3_frame_buf_ctrl: buffers exceed the DDR3 address space");
  end

  function automatic logic [ADDR_WIDTH-1:0] base_of(input logic [BUF_IDX_W-1:0] idx);
    logic [CALC_W-1:0] full;
    full = buf_base(CALC_W'(BASE_ADDR), CALC_W'(FRAME_SPAN), idx);
    return full[ADDR_WIDTH-1:0];
  endfunction

  logic                  wr_req_reg, rd_req_reg;
  logic [ADDR_WIDTH-1:0] wr_begin_reg, wr_end_reg, rd_begin_reg, rd_end_reg;
  logic [BUF_IDX_W-1:0]  wr_buf_idx_reg, rd_buf_idx_reg, ready_idx_reg;
  logic                  writing_reg, ready_vld_reg, rd_active_reg, frame_valid_reg;
  logic [CNT_WIDTH-1:0]  drop_cnt_reg;

  logic                  done_fire, take, rd_fire, ovw_fire, done_drop;
  logic                  ready_vld_a, ready_vld_b, rd_active_b, frame_valid_b;
  logic [BUF_IDX_W-1:0]  ready_idx_a, rd_idx_b, sel_idx;
  logic                  sel_overwrite;
  logic [1:0]            drop_inc;
  logic [CNT_WIDTH+1:0]  drop_sum;
  logic [CNT_WIDTH-1:0]  drop_cnt_next;

  // Same-cycle events resolve as done -> read start -> write start, so each
  // stage below consumes the state left by the previous one.
  always_comb begin
    done_fire     = wr_frame_done && writing_reg;
    done_drop     = done_fire && ready_vld_reg;
    ready_vld_a   = done_fire ? 1'b1 : ready_vld_reg;
    ready_idx_a   = done_fire ? wr_buf_idx_reg : ready_idx_reg;
    take          = rd_frame_start && ready_vld_a;
    ready_vld_b   = take ? 1'b0 : ready_vld_a;
    rd_idx_b      = take ? ready_idx_a : rd_buf_idx_reg;
    rd_active_b   = rd_active_reg || take;
    frame_valid_b = frame_valid_reg || take;
    rd_fire       = rd_frame_start && frame_valid_b;
    ovw_fire      = wr_frame_start && sel_overwrite;
    drop_inc      = {1'b0, done_drop} + {1'b0, ovw_fire};
    drop_sum      = {2'b00, drop_cnt_reg} + {{CNT_WIDTH{1'b0}}, drop_inc};
    drop_cnt_next = (drop_sum > {2'b00, {CNT_WIDTH{1'b1}}}) ? {CNT_WIDTH{1'b1}}
                                                            : drop_sum[CNT_WIDTH-1:0];
  end

  ddr3_buf_sel #(.BUF_NUM(BUF_NUM)) u_sel (
    .cur_idx   (wr_buf_idx_reg),
    .rd_idx    (rd_idx_b),
    .rd_active (rd_active_b),
    .ready_idx (ready_idx_a),
    .ready_vld (ready_vld_b),
    .sel_idx   (sel_idx),
    .overwrite (sel_overwrite)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_req_reg      <= 1'b0;
      rd_req_reg      <= 1'b0;
      wr_begin_reg    <= '0;
      wr_end_reg      <= '0;
      rd_begin_reg    <= '0;
      rd_end_reg      <= '0;
      wr_buf_idx_reg  <= BUF_IDX_W'(BUF_NUM - 1);
      rd_buf_idx_reg  <= '0;
      ready_idx_reg   <= '0;
      writing_reg     <= 1'b0;
      ready_vld_reg   <= 1'b0;
      rd_active_reg   <= 1'b0;
      frame_valid_reg <= 1'b0;
      drop_cnt_reg    <= '0;
    end else begin
      wr_req_reg      <= wr_frame_start;
      rd_req_reg      <= rd_fire;
      ready_idx_reg   <= ready_idx_a;
      ready_vld_reg   <= ovw_fire ? 1'b0 : ready_vld_b;
      rd_buf_idx_reg  <= rd_idx_b;
      rd_active_reg   <= rd_active_b;
      frame_valid_reg <= frame_valid_b;
      drop_cnt_reg    <= drop_cnt_next;
      if (wr_frame_start) begin
        writing_reg    <= 1'b1;
        wr_buf_idx_reg <= sel_idx;
        wr_begin_reg   <= base_of(sel_idx);
        wr_end_reg     <= base_of(sel_idx) + FRAME_SPAN;
      end else if (done_fire) begin
        writing_reg <= 1'b0;
      end
      if (rd_fire) begin
        rd_begin_reg <= base_of(rd_idx_b);
        rd_end_reg   <= base_of(rd_idx_b) + FRAME_SPAN;
      end
    end
  end

  assign wr_req           = wr_req_reg;
  assign rd_req           = rd_req_reg;
  assign wr_address_beign = wr_begin_reg;
  assign wr_address_end   = wr_end_reg;
  assign rd_address_beign = rd_begin_reg;
  assign rd_address_end   = rd_end_reg;
  assign wr_buf_idx       = wr_buf_idx_reg;
  assign rd_buf_idx       = rd_buf_idx_reg;
  assign frame_valid      = frame_valid_reg;
  assign drop_cnt         = drop_cnt_reg;
endmodule

// File: tb/tb_ddr3_frame_buf_ctrl.sv
// Bench for ddr3_frame_buf_ctrl (3- and 2-buffer instances) plus the selector.
module tb_ddr3_frame_buf_ctrl;
  localparam logic [27:0] SPAN = 28'h020_0000;
  localparam bit [2:0] NONE = 3'b000, WS = 3'b001, RS = 3'b010, WD = 3'b100;

  typedef struct packed {
    logic [1:0]  wr_idx, rd_idx, ready_idx;
    logic        writing, ready_vld, rd_active, frame_valid, wr_req, rd_req;
    logic [7:0]  drop;
    logic [27:0] wb, we, rb, re;
  } mst_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic ws3 = 0, wd3 = 0, rs3 = 0, ws2 = 0, wd2 = 0, rs2 = 0;
  logic wq3, rq3, fv3, wq2, rq2, fv2;
  logic [27:0] wb3, we3, rb3, re3, wb2, we2, rb2, re2;
  logic [1:0]  wi3, ri3, wi2, ri2;
  logic [7:0]  dc3, dc2;
  logic [1:0]  s_cur = 0, s_rd = 0, s_ready = 0, s_sel;
  logic        s_rda = 0, s_rv = 0, s_ow;
  mst_t m3, m2;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  ddr3_frame_buf_ctrl #(.BUF_NUM(3)) u3 (
    .clk(clk), .rst_n(rst_n), .wr_frame_start(ws3), .wr_frame_done(wd3),
    .rd_frame_start(rs3), .wr_req(wq3), .wr_address_beign(wb3), .wr_address_end(we3),
    .rd_req(rq3), .rd_address_beign(rb3), .rd_address_end(re3), .wr_buf_idx(wi3),
    .rd_buf_idx(ri3), .frame_valid(fv3), .drop_cnt(dc3));

  ddr3_frame_buf_ctrl #(.BUF_NUM(2)) u2 (
    .clk(clk), .rst_n(rst_n), .wr_frame_start(ws2), .wr_frame_done(wd2),
    .rd_frame_start(rs2), .wr_req(wq2), .wr_address_beign(wb2), .wr_address_end(we2),
    .rd_req(rq2), .rd_address_beign(rb2), .rd_address_end(re2), .wr_buf_idx(wi2),
    .rd_buf_idx(ri2), .frame_valid(fv2), .drop_cnt(dc2));

  ddr3_buf_sel #(.BUF_NUM(2)) u_sel (
    .cur_idx(s_cur), .rd_idx(s_rd), .rd_active(s_rda), .ready_idx(s_ready),
    .ready_vld(s_rv), .sel_idx(s_sel), .overwrite(s_ow));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic mst_t m_reset(input int n);
    mst_t s;
    s = '0;
    s.wr_idx = 2'(n - 1);
    return s;
  endfunction

  // Frame-level model: busy buffers are the one on screen and the newest
  // finished frame; the writer takes the next buffer in rotation that is free.
  function automatic mst_t m_step(input mst_t s0, input int n, input bit wd, input bit rs, input bit ws);
    mst_t s;
    bit   busy [4];
    int   pick;
    s = s0;
    s.wr_req = 1'b0;
    s.rd_req = 1'b0;
    if (wd && s.writing) begin
      if (s.ready_vld && s.drop != 8'hFF) s.drop++;
      s.ready_idx = s.wr_idx;
      s.ready_vld = 1'b1;
      s.writing   = 1'b0;
    end
    if (rs) begin
      if (s.ready_vld) begin
        s.rd_idx = s.ready_idx; s.ready_vld = 0; s.rd_active = 1; s.frame_valid = 1;
      end
      if (s.frame_valid) begin
        s.rd_req = 1'b1;
        s.rb = 28'(s.rd_idx) * SPAN;
        s.re = s.rb + SPAN;
      end
    end
    if (ws) begin
      busy = '{default: 1'b0};
      if (s.rd_active) busy[s.rd_idx] = 1'b1;
      if (s.ready_vld) busy[s.ready_idx] = 1'b1;
      pick = -1;
      for (int k = 1; k <= n; k++)
        if (pick < 0 && !busy[(s.wr_idx + k) % n]) pick = (s.wr_idx + k) % n;
      if (pick < 0) begin
        for (int k = 1; k <= n; k++)
          if (pick < 0 && !(s.rd_active && ((s.wr_idx + k) % n) == s.rd_idx))
            pick = (s.wr_idx + k) % n;
        s.ready_vld = 1'b0;
        if (s.drop != 8'hFF) s.drop++;
      end
      s.wr_idx  = 2'(pick);
      s.writing = 1'b1;
      s.wr_req  = 1'b1;
      s.wb = 28'(pick) * SPAN;
      s.we = s.wb + SPAN;
    end
    return s;
  endfunction

  task automatic check_inst(input string t, input mst_t m, input logic wq, input logic rq,
                            input logic [27:0] wb, input logic [27:0] we, input logic [27:0] rb,
                            input logic [27:0] re, input logic [1:0] wi, input logic [1:0] ri,
                            input logic fv, input logic [7:0] dc);
    chk({t, ".wr_req"}, wq, m.wr_req);
    chk({t, ".rd_req"}, rq, m.rd_req);
    chk({t, ".wr_begin"}, wb, m.wb);
    chk({t, ".wr_end"}, we, m.we);
    chk({t, ".rd_begin"}, rb, m.rb);
    chk({t, ".rd_end"}, re, m.re);
    chk({t, ".wr_buf_idx"}, wi, m.wr_idx);
    chk({t, ".rd_buf_idx"}, ri, m.rd_idx);
    chk({t, ".frame_valid"}, fv, m.frame_valid);
    chk({t, ".drop_cnt"}, dc, m.drop);
  endtask

  always @(negedge clk) begin
    check_inst("u3", m3, wq3, rq3, wb3, we3, rb3, re3, wi3, ri3, fv3, dc3);
    check_inst("u2", m2, wq2, rq2, wb2, we2, rb2, re2, wi2, ri2, fv2, dc2);
  end

  task automatic cyc(input bit [2:0] p3, input bit [2:0] p2);
    {wd3, rs3, ws3} = p3;
    {wd2, rs2, ws2} = p2;
    @(posedge clk);
    if (rst_n) begin
      m3 = m_step(m3, 3, p3[2], p3[1], p3[0]);
      m2 = m_step(m2, 2, p2[2], p2[1], p2[0]);
    end
    #1;
    {wd3, rs3, ws3, wd2, rs2, ws2} = '0;
    $display("cyc t=%0t u3{wd,rs,ws}=%b u2=%b wr3=%0d rd3=%0d drop3=%0d wr2=%0d rd2=%0d drop2=%0d",
             $time, p3, p2, wi3, ri3, dc3, wi2, ri2, dc2);
  endtask

  initial begin
    m3 = m_reset(3);
    m2 = m_reset(2);
    repeat (2) @(posedge clk);
    #1;
    chk("rst u3 wr_buf_idx", wi3, 2);
    chk("rst u2 wr_buf_idx", wi2, 1);
    chk("rst u3 drop_cnt", dc3, 0);
    chk("rst u3 wr_begin", wb3, 0);
    rst_n = 1'b1;

    // 1: first write goes to buffer 0; read before any frame is silent
    cyc(WS, NONE);
    chk("t1 wr_req", wq3, 1);
    chk("t1 wr_buf_idx", wi3, 0);
    chk("t1 wr_begin", wb3, 28'h000_0000);
    chk("t1 wr_end", we3, 28'h020_0000);
    cyc(NONE, NONE);
    chk("t1 wr_req one cycle", wq3, 0);
    cyc(RS, NONE);
    chk("t1 rd_req none", rq3, 0);
    chk("t1 frame_valid", fv3, 0);

    // 2: reader picks up buffer 0, writer moves to 1
    cyc(WD, NONE);
    cyc(RS, NONE);
    chk("t2 rd_req", rq3, 1);
    chk("t2 rd_buf_idx", ri3, 0);
    chk("t2 rd_begin", rb3, 28'h000_0000);
    chk("t2 frame_valid", fv3, 1);
    cyc(WS, NONE);
    chk("t2 wr_buf_idx", wi3, 1);
    chk("t2 wr_begin", wb3, 28'h020_0000);
    chk("t2 wr_end", we3, 28'h040_0000);

    // 3: two unread frames -> one drop; next write avoids reader and ready
    cyc(WD, NONE);
    cyc(WS, NONE);
    chk("t3 wr_buf_idx", wi3, 2);
    cyc(WD, NONE);
    chk("t3 drop_cnt", dc3, 1);
    cyc(WS, NONE);
    chk("t3 wr skips", wi3, 1);

    // 4: done and read start together
    cyc(RS, NONE);
    chk("t4 pre rd_buf_idx", ri3, 2);
    cyc(WD | RS, NONE);
    chk("t4 rd_req", rq3, 1);
    chk("t4 rd_buf_idx", ri3, 1);
    chk("t4 rd_begin", rb3, 28'h020_0000);
    chk("t4 drop_cnt", dc3, 1);
    cyc(WS, NONE);
    cyc(WD | RS | WS, NONE);
    chk("t4b rd_buf_idx", ri3, 2);
    chk("t4b wr_buf_idx", wi3, 0);

    // aborted frame: buffer 0 never becomes ready
    cyc(WS, NONE);
    chk("abort wr_buf_idx", wi3, 1);
    cyc(WD, NONE);
    cyc(RS, NONE);
    chk("abort rd_buf_idx", ri3, 1);

    // drop counter saturation
    for (int i = 0; i < 300; i++) begin
      cyc(WS, NONE);
      cyc(WD, NONE);
    end
    chk("sat drop_cnt", dc3, 8'hFF);

    // 5: two buffers, ready frame overwritten
    cyc(NONE, WS);
    cyc(NONE, WD);
    cyc(NONE, RS);
    cyc(NONE, WS);
    cyc(NONE, WD);
    cyc(NONE, WS);
    chk("t5 wr_buf_idx", wi2, 1);
    chk("t5 drop_cnt", dc2, 1);
    cyc(NONE, RS);
    chk("t5 rd_req", rq2, 1);
    chk("t5 rd_buf_idx", ri2, 0);

    // 6: reset lands while a write start is pending
    ws3 = 1'b1;
    ws2 = 1'b1;
    #2;
    rst_n = 1'b0;
    m3 = m_reset(3);
    m2 = m_reset(2);
    @(posedge clk);
    #1;
    {ws3, ws2} = '0;
    chk("t6 wr_req killed", wq3, 0);
    chk("t6 wr_buf_idx", wi3, 2);
    chk("t6 drop_cnt", dc3, 0);
    chk("t6 frame_valid", fv3, 0);
    chk("t6 rd_end", re3, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(WS, WS);
    chk("t6 post wr_buf_idx u3", wi3, 0);
    chk("t6 post wr_req", wq3, 1);
    chk("t6 post wr_buf_idx u2", wi2, 0);

    // standalone selector, two buffers
    s_cur = 1; s_rd = 0; s_rda = 1; s_ready = 1; s_rv = 1;
    #1;
    chk("sel ovw idx", s_sel, 1);
    chk("sel ovw flag", s_ow, 1);
    s_cur = 0; s_rda = 0; s_rv = 0;
    #1;
    chk("sel free idx", s_sel, 1);
    chk("sel free flag", s_ow, 0);

    repeat (3) cyc(NONE, NONE);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
